// File: rtl/t03_nes_controller_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : t03_nes_controller_driver_if
// Description : Controller pins and downstream shift-stage handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface t03_nes_controller_driver_if;
    logic enable;
    logic nes_data_in;
    logic nes_latch;
    logic nes_pulse;
    logic data;
    logic button_en;
    logic finished;
    logic busy;

    modport master (
        input  enable, nes_data_in,
        output nes_latch, nes_pulse, data, button_en, finished, busy
    );

    modport slave (
        output enable, nes_data_in,
        input  nes_latch, nes_pulse, data, button_en, finished, busy
    );
endinterface
`default_nettype wire

// File: rtl/t03_nes_controller_driver.sv
`default_nettype none
// ============================================================================
// Module      : t03_nes_controller_driver
// Description : NES controller poller: latch/pulse generation, 2-flop data sync,
//               per-bit button_en strobe and end-of-poll finished strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module t03_nes_controller_driver #(
    parameter int POLL_CYCLES     = 166667,
    parameter int LATCH_CYCLES    = 120,
    parameter int HALF_BIT_CYCLES = 60
) (
    input  wire logic clk,
    input  wire logic rst,
    t03_nes_controller_driver_if.master bus
);

    localparam int c_POLL_W = $clog2(POLL_CYCLES);
    localparam int c_PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_POLL_W-1:0] c_POLL_LOAD  = c_POLL_W'(POLL_CYCLES - 1);
    localparam logic [c_PH_W-1:0]   c_LATCH_LOAD = c_PH_W'(LATCH_CYCLES - 1);
    localparam logic [c_PH_W-1:0]   c_HALF_LOAD  = c_PH_W'(HALF_BIT_CYCLES - 1);
    localparam logic [c_PH_W-1:0]   c_PH_ONE     = c_PH_W'(1);
    localparam logic [2:0]          c_LAST_BIT   = 3'd7;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_LATCH = 3'd1,
        S_GAP   = 3'd2,
        S_PULSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_POLL_W-1:0] r_pollCnt;
    logic [c_PH_W-1:0]   r_phase;
    logic [2:0]          r_bitIdx;
    logic                r_latch;
    logic                r_pulse;
    logic                r_buttonEn;
    logic                r_finished;
    logic                r_busy;
    logic                r_sync1;
    logic                r_sync2;

    // Idle level of the controller line is 1 (nothing pressed).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.nes_data_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT;
            r_pollCnt  <= '0;
            r_phase    <= '0;
            r_bitIdx   <= '0;
            r_latch    <= 1'b0;
            r_pulse    <= 1'b0;
            r_buttonEn <= 1'b0;
            r_finished <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_buttonEn <= 1'b0;
            r_finished <= 1'b0;
            // Free-running frame timer; reloaded only when a poll starts.
            if (r_pollCnt != '0) begin
                r_pollCnt <= r_pollCnt - 1'b1;
            end
            case (r_state)
                S_WAIT: begin
                    if (bus.enable && (r_pollCnt == '0)) begin
                        r_state   <= S_LATCH;
                        r_latch   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_phase   <= c_LATCH_LOAD;
                        r_pollCnt <= c_POLL_LOAD;
                    end
                end
                S_LATCH: begin
                    if (r_phase == '0) begin
                        r_state  <= S_GAP;
                        r_latch  <= 1'b0;
                        r_phase  <= c_HALF_LOAD;
                        r_bitIdx <= '0;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_phase == '0) begin
                        if (r_bitIdx == c_LAST_BIT) begin
                            r_state    <= S_DONE;
                            r_finished <= 1'b1;
                        end else begin
                            r_state  <= S_PULSE;
                            r_pulse  <= 1'b1;
                            r_phase  <= c_HALF_LOAD;
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase - 1'b1;
                        // Registered strobe lands on the final GAP cycle.
                        if (r_phase == c_PH_ONE) begin
                            r_buttonEn <= 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (r_phase == '0) begin
                        r_state <= S_GAP;
                        r_pulse <= 1'b0;
                        r_phase <= c_HALF_LOAD;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_WAIT;
                    r_latch <= 1'b0;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nes_latch = r_latch;
    assign bus.nes_pulse = r_pulse;
    assign bus.data      = r_sync2;
    assign bus.button_en = r_buttonEn;
    assign bus.finished  = r_finished;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_t03_nes_controller_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_t03_nes_controller_driver
// Description : Randomized bench with a timing-formula reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t03_nes_controller_driver;

    localparam int c_L   = 4;
    localparam int c_H   = 4;
    localparam int c_P   = 100;
    localparam int c_SEQ = c_L + 15 * c_H;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    t03_nes_controller_driver_if bus ();

    t03_nes_controller_driver #(
        .POLL_CYCLES    (c_P),
        .LATCH_CYCLES   (c_L),
        .HALF_BIT_CYCLES(c_H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model state: poll start cycle and input/reset history
    int   t0       = 0;
    bit   havePoll = 0;
    int   pollNum  = 0;
    logic rstH1 = 1'b1, rstH2 = 1'b1;
    logic inH1 = 1'b1, inH2 = 1'b1;
    logic enPrev = 1'b0, busyPrev = 1'b0;

    // Observation-side downstream shift stage and per-poll counters
    logic [7:0] shReg = 8'h00;
    logic [7:0] capByte = 8'h00;
    int   capCount = 0;
    int   nBen = 0, nPulse = 0;
    logic prevLatch = 1'b0, prevPulse = 1'b0;

    always @(negedge clk) begin
        int   r;
        bit   inPoll;
        logic [5:0] expV, obsV;
        if (!rst && !rstH1 && enPrev && !busyPrev && (!havePoll || (cyc - 1 >= t0 + c_P - 1))) begin
            t0       = cyc;
            havePoll = 1;
            pollNum++;
        end
        if (rst) havePoll = 0;
        r      = cyc - t0;
        inPoll = havePoll && (r >= 0) && (r <= c_SEQ);
        expV[5] = inPoll && (r < c_L);
        expV[4] = inPoll && (r >= c_L) && (r < c_L + 15 * c_H) && ((((r - c_L) / c_H) % 2) == 1);
        expV[3] = (rst || rstH1 || rstH2) ? 1'b1 : inH2;
        expV[2] = inPoll && (r >= c_L) && (r < c_L + 15 * c_H) && (((r - c_L) % (2 * c_H)) == c_H - 1);
        expV[1] = inPoll && (r == c_SEQ);
        expV[0] = inPoll;
        obsV = {bus.nes_latch, bus.nes_pulse, bus.data, bus.button_en, bus.finished, bus.busy};
        check("outs", {26'd0, obsV}, {26'd0, expV});

        if (bus.nes_latch && !prevLatch) begin
            nBen   = 0;
            nPulse = 0;
        end
        if (bus.nes_pulse && !prevPulse) nPulse++;
        if (bus.button_en) begin
            nBen++;
            shReg = {shReg[6:0], bus.data};
        end
        if (bus.finished) begin
            check("n_button_en", nBen, 8);
            check("n_pulse_rise", nPulse, 7);
            capByte = shReg;
            capCount++;
        end
        prevLatch = bus.nes_latch;
        prevPulse = bus.nes_pulse;

        rstH2    = rstH1;
        rstH1    = rst;
        inH2     = inH1;
        inH1     = bus.nes_data_in;
        enPrev   = bus.enable;
        busyPrev = expV[0];
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitPoll();
        int p0 = pollNum;
        int n  = 0;
        while (pollNum == p0 && n < 400) begin
            step(1);
            n++;
        end
        check("poll_start_timeout", {31'd0, pollNum != p0}, 32'd1);
    endtask

    task automatic waitCycle(input int target);
        int n = 0;
        while (cyc < target && n < 400) begin
            step(1);
            n++;
        end
    endtask

    // Drive each button bit at the start of its GAP, MSB (A) first.
    task automatic runPattern(input logic [7:0] pat);
        int c0;
        int n = 0;
        waitPoll();
        for (int k = 0; k < 8; k++) begin
            waitCycle(t0 + c_L + 2 * k * c_H);
            bus.nes_data_in = pat[7 - k];
        end
        c0 = capCount;
        while (capCount == c0 && n < 200) begin
            step(1);
            n++;
        end
        check("captured_byte", {24'd0, capByte}, {24'd0, pat});
        bus.nes_data_in = 1'b1;
    endtask

    task automatic randomRun(input int n);
        repeat (n) begin
            step(1);
            bus.nes_data_in = 1'($urandom);
            bus.enable      = ($urandom_range(0, 15) != 0);
        end
        bus.enable = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.nes_data_in = 1'b1;
        step(3);
        rst = 1'b0;
        step(220);

        runPattern(8'h6F);
        repeat (3) begin
            b = 8'($urandom);
            runPattern(b);
        end
        randomRun(350);

        // Held off after reset, then enabled.
        rst        = 1'b1;
        bus.enable = 1'b0;
        step(2);
        rst = 1'b0;
        step(300);
        bus.enable = 1'b1;
        step(150);

        // Enable dropped mid-poll.
        waitPoll();
        waitCycle(t0 + 20);
        bus.enable = 1'b0;
        step(250);
        bus.enable = 1'b1;

        // Reset mid-poll.
        waitPoll();
        waitCycle(t0 + 30);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(200);

        randomRun(400);
        step(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t03_nes_controller_driver.md
Name: t03_nes_controller_driver

Overview:
Generates the NES controller protocol (latch and pulse pins) and samples the controller's serial data pin. It presents one synchronized data bit per button with a one-cycle button_en strobe, then a one-cycle finished strobe after the 8th bit. It feeds the team's eight-bit shift/latch stage directly: data to data, button_en to button_en, finished to finished. It polls at a fixed frame rate.

Parameters:
POLL_CYCLES, 166667, clk cycles between successive poll starts (60 Hz at 10 MHz); must be > LATCH_CYCLES + 15*HALF_BIT_CYCLES + 2
LATCH_CYCLES, 120, cycles nes_latch is held high (12 us at 10 MHz); >= 1
HALF_BIT_CYCLES, 60, cycles per pulse-low or pulse-high phase (6 us at 10 MHz); >= 4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  allow new polls to start
nes_data_in  input  1  raw controller serial pin, asynchronous, active-low (0 = pressed)
nes_latch  output  1  controller latch pin
nes_pulse  output  1  controller clock pin
data  output  1  synchronized serial bit, polarity unchanged (active-low)
button_en  output  1  one-cycle strobe: data is valid, shift now
finished  output  1  one-cycle strobe: all 8 bits delivered
busy  output  1  poll sequence in progress

Behaviour:
- Reset is asynchronous and active-high. Clock is clk. Reset values: nes_latch=0, nes_pulse=0, button_en=0, finished=0, busy=0, data=1. Synchronizer flops=1, state=WAIT, poll counter=0, bit index=0.
- Synchronizer: two flops on nes_data_in. data is the second flop's output, so latency is 2 cycles. No inversion is applied.
- Poll counter: width $clog2(POLL_CYCLES), counts down to 0 and saturates at 0.
  - Loaded with POLL_CYCLES-1 on the cycle the FSM enters LATCH.
  - The poll period is independent of sequence length.
- FSM states:
  - WAIT: all strobes low. If enable=1 and poll counter=0, go to LATCH. The first poll starts one cycle after rst deasserts when enable=1.
  - LATCH: nes_latch=1 for LATCH_CYCLES cycles, then go to GAP with bit index=0.
  - GAP: nes_pulse=0 for HALF_BIT_CYCLES cycles. On the last GAP cycle, button_en=1. Then:
    - if bit index=7, go to DONE;
    - otherwise increment bit index and go to PULSE.
  - PULSE: nes_pulse=1 for HALF_BIT_CYCLES cycles, then go to GAP.
  - DONE: finished=1 for exactly one cycle, then go to WAIT.
- Timing, with cycle 0 = first LATCH cycle, L = LATCH_CYCLES, H = HALF_BIT_CYCLES:
  - nes_latch is high in cycles 0..L-1.
  - The bit-k button_en (k=0..7) is at cycle L+(2k+1)H-1.
  - There are 7 nes_pulse high phases in total. Bit 0 (A) is valid after latch, so no pulse precedes it.
  - finished is at cycle L+15H, one cycle after the 8th button_en, so the downstream stage latches after the 8th shift has landed.
  - busy is high from cycle 0 through the finished cycle inclusive.
- Bit order: A, B, Select, Start, Up, Down, Left, Right. The first bit ends up in the downstream MSB.
- button_en and finished are never high in the same cycle. There are exactly 8 button_en strobes per finished strobe.
- If enable drops mid-poll, the current poll completes; no new poll starts until enable=1 again.
- If rst asserts mid-poll, all outputs immediately take their reset values, no finished is issued, and the partial poll is discarded.
- nes_latch and nes_pulse are never high in the same cycle.

Test Plan:
- L=4, H=4, POLL=100, enable=1, nes_data_in held at 1 -> nes_latch high cycles 0-3; button_en at 7,15,23,31,39,47,55,63; finished at 64; data=1 at every strobe; the next latch starts at cycle 100.
- Same parameters, nes_data_in driven per bit to 0,1,1,0,1,1,1,1, each bit changed at the start of its GAP -> data sampled at the strobes matches this sequence; the downstream shift stage latches 8'h6F.
- enable=0 after reset for 300 cycles -> nes_latch, nes_pulse, button_en and busy stay 0; raise enable -> the latch starts one cycle later.
- enable dropped at cycle 20 of a poll -> all 8 button_en strobes and finished still occur; no second latch while enable=0.
- rst asserted at cycle 30 of a poll -> outputs go to reset values in the same cycle and no finished occurs; after release, a fresh poll gives exactly 8 button_en strobes and 1 finished.
- Over 3 consecutive polls -> exactly 7 nes_pulse rising edges per poll; nes_latch and nes_pulse never overlap; button_en and finished never coincide.
